ex_muldiv_unit: RTL

//  Iterative RV32M multiply/divide execute unit; sits in EX beside the single-cycle ALU.

---
 rtl/ex_muldiv_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply, restoring divide.
// Stalls the pipeline while iterating and returns the result with its destination register tag.
module ex_muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MUL_STEP   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [XLEN-1:0]       opr1_i,
  input  logic [XLEN-1:0]       opr2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  output logic                  ex_stall_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [XLEN-1:0]       wdata_o
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              op_q;
  logic                    neg_q;
  logic                    wreg_q;
  logic [REG_ADDR_W-1:0]   wd_pend_q;
  logic [REG_ADDR_W-1:0]   wd_q;
  logic [2*XLEN-1:0]       acc_q;
  logic [2*XLEN-1:0]       mcand_q;
  logic [XLEN-1:0]         opb_q;
  logic [CW-1:0]           cnt_q;
  logic [XLEN-1:0]         wdata_q;

  logic                    accept, is_div, sign1, sign2, div_zero, div_ovf, fast;
  logic [XLEN-1:0]         mag1, mag2, fast_val;
  logic [2*XLEN-1:0]       mul_acc, div_acc, acc_nx, prod;
  logic [XLEN:0]           trial;
  logic [XLEN-1:0]         quo, rem, result;

  // Operand decode: magnitudes for signed ops, and the divide cases that skip iteration
  always_comb begin
    accept   = (state_q == IDLE) && start_i && !flush_i;
    is_div   = op_i[2];
    sign1    = ((op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM))
               && opr1_i[XLEN-1];
    sign2    = ((op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM)) && opr2_i[XLEN-1];
    mag1     = sign1 ? -opr1_i : opr1_i;
    mag2     = sign2 ? -opr2_i : opr2_i;
    div_zero = is_div && (opr2_i == '0);
    div_ovf  = is_div && !op_i[0] && (opr1_i == MIN_NEG) && (opr2_i == '1);
    fast     = div_zero || div_ovf;
    if (div_zero) fast_val = op_i[1] ? opr1_i : '1;
    else          fast_val = op_i[1] ? '0 : opr1_i;
  end

  // One iteration step; the divide keeps {remainder, quotient} packed in acc_q
  always_comb begin
    mul_acc = acc_q + mcand_q * {{(2*XLEN-MUL_STEP){1'b0}}, opb_q[MUL_STEP-1:0]};
    trial   = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
    if (trial[XLEN]) div_acc = {acc_q[2*XLEN-2:0], 1'b0};
    else             div_acc = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    acc_nx = op_q[2] ? div_acc : mul_acc;
    prod   = neg_q ? -acc_nx : acc_nx;
    quo    = neg_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
    rem    = neg_q ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                       result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result = quo;
      default:                      result = rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = fast ? DONE : CALC;
      CALC:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      neg_q     <= 1'b0;
      wreg_q    <= 1'b0;
      wd_pend_q <= '0;
      wd_q      <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      wdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= op_i;
        wd_pend_q <= wd_i;
        wreg_q    <= wreg_i;
        neg_q     <= (is_div && op_i[1]) ? sign1 : (sign1 ^ sign2);
        opb_q     <= mag2;
        mcand_q   <= {{XLEN{1'b0}}, mag1};
        acc_q     <= is_div ? {{XLEN{1'b0}}, mag1} : '0;
        cnt_q     <= is_div ? CW'(XLEN - 1) : CW'(XLEN / MUL_STEP - 1);
        if (fast) begin
          wdata_q <= fast_val;
          wd_q    <= wd_i;
        end
      end else if ((state_q == CALC) && !flush_i) begin
        acc_q   <= acc_nx;
        mcand_q <= mcand_q << MUL_STEP;
        opb_q   <= op_q[2] ? opb_q : (opb_q >> MUL_STEP);
        cnt_q   <= cnt_q - CW'(1);
        if (cnt_q == '0) begin
          wdata_q <= result;
          wd_q    <= wd_pend_q;
        end
      end
    end
  end

  // A flush landing on the DONE cycle kills the writeback as well
  assign done_o     = (state_q == DONE) && !flush_i;
  assign wreg_o     = done_o && wreg_q;
  assign busy_o     = (state_q != IDLE);
  assign ex_stall_o = accept || (state_q == CALC);
  assign wd_o       = wd_q;
  assign wdata_o    = wdata_q;

endmodule
